truth_table_sweeper: RTL and testbench



---
 rtl/truth_table_sweeper_if.sv | 35 +++
 rtl/truth_table_sweeper.sv | 125 ++++++++++++
 tb/tb_truth_table_sweeper.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/truth_table_sweeper_if.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweeper_if
// Description : Control/stimulus bundle between a sweep controller and its
//               user. Carries start/gray/pause requests, the function
//               block's Y return, the B/C/D stimulus, and the status and
//               result outputs (busy, done, table_out, ones_cnt).
//               slave  : the sweeper side (drives stimulus and results)
//               master : the user side (drives requests and Y)
// Revision    : 1.0  initial release
// ============================================================================
interface truth_table_sweeper_if;
  logic       start;
  logic       gray;
  logic       pause;
  logic       Y;
  logic       B;
  logic       C;
  logic       D;
  logic       busy;
  logic       done;
  logic [7:0] table_out;
  logic [3:0] ones_cnt;

  modport slave (
    input  start, gray, pause, Y,
    output B, C, D, busy, done, table_out, ones_cnt
  );

  modport master (
    output start, gray, pause, Y,
    input  B, C, D, busy, done, table_out, ones_cnt
  );
endinterface
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweeper
// Description : Drives a 3-input combinational block through all eight
//               input codes (binary or Gray order), holds each code for
//               SETTLE cycles, samples Y, and builds an 8-bit truth table
//               indexed by the applied code plus a count of ones.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - truth_table_sweeper_if.slave
//                       in : start, gray, pause, Y
//                       out: B, C, D (registered code, B = MSB), busy,
//                            done (1-cycle pulse), table_out[7:0],
//                            ones_cnt[3:0]
// Parameters  : SETTLE - hold cycles per vector before sampling (1..15)
// Revision    : 1.0  initial release
// ============================================================================
module truth_table_sweeper #(
  parameter int SETTLE = 1
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  truth_table_sweeper_if.slave bus
);

  localparam logic [3:0] C_SCNT_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t     r_state;
  logic [2:0] r_idx;
  logic [3:0] r_scnt;
  logic       r_gm;
  logic [2:0] r_code;
  logic       r_busy;
  logic       r_done;
  logic [7:0] r_table;
  logic [3:0] r_ones;

  logic [2:0] w_idx_next;

  assign w_idx_next = r_idx + 3'd1;

  // Code applied for a given index: plain binary, or reflected Gray.
  function automatic logic [2:0] f_code(input logic [2:0] idx, input logic gm);
    return gm ? (idx ^ (idx >> 1)) : idx;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= 3'd0;
      r_scnt  <= 4'd0;
      r_gm    <= 1'b0;
      r_code  <= 3'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_table <= 8'd0;
      r_ones  <= 4'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_idx   <= 3'd0;
            r_gm    <= bus.gray;
            r_table <= 8'd0;
            r_ones  <= 4'd0;
            r_scnt  <= 4'd0;
            r_code  <= 3'd0;  // code(0) is 000 in both orders
            r_busy  <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!bus.pause) begin
            if (r_scnt == C_SCNT_LAST) begin
              r_scnt  <= 4'd0;
              r_state <= S_SAMPLE;
            end else begin
              r_scnt <= r_scnt + 4'd1;
            end
          end
        end
        S_SAMPLE: begin
          if (!bus.pause) begin
            // Index by the applied code so both orders give the same table.
            r_table[r_code] <= bus.Y;
            r_ones          <= r_ones + {3'd0, bus.Y};
            if (r_idx == 3'd7) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_idx   <= w_idx_next;
              r_code  <= f_code(w_idx_next, r_gm);
              r_state <= S_WAIT;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.B         = r_code[2];
  assign bus.C         = r_code[1];
  assign bus.D         = r_code[0];
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.table_out = r_table;
  assign bus.ones_cnt  = r_ones;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_truth_table_sweeper
// Description : Directed bench for truth_table_sweeper. Instance dut uses
//               SETTLE = 1 with a selectable Y source; instance dut3 uses
//               SETTLE = 3 with Y tied high.
// Revision    : 1.0  initial release
// ============================================================================
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   y_sel = 0;   // 0: D & (~C | B), 1: constant 1, 2: constant 0
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  truth_table_sweeper_if bus ();
  truth_table_sweeper_if bus3 ();

  truth_table_sweeper #(.SETTLE(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  truth_table_sweeper #(.SETTLE(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  assign bus.Y  = (y_sel == 0) ? (bus.D & (~bus.C | bus.B)) : (y_sel == 1);
  assign bus3.Y = 1'b1;

  logic [2:0] gseq [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one sweep on dut from IDLE. Pause windows are inclusive cycle
  // ranges counted from the start edge (cycle 1 = first WAIT cycle).
  task automatic sweep(input string tag, input bit g, input bit toggle,
                       input bit hold_start,
                       input int p1lo, input int p1hi, input logic [2:0] p1code,
                       input int p2lo, input int p2hi, input logic [2:0] p2code,
                       input bit chk_seq, input logic [7:0] exp_tab,
                       input logic [3:0] exp_ones, input int exp_done);
    int n;
    bit seen;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.gray  = g;
    @(posedge clk); #1;
    bus.start = hold_start;
    seen = 1'b0;
    n = 1;
    while (!seen && n <= 80) begin
      bus.pause = (n >= p1lo && n <= p1hi) || (n >= p2lo && n <= p2hi);
      if (toggle) bus.gray = ~bus.gray;
      @(negedge clk);
      if (chk_seq && n <= 16 && n[0])
        check({tag, " code"}, {29'd0, bus.B, bus.C, bus.D},
              {29'd0, g ? gseq[(n - 1) / 2] : 3'((n - 1) / 2)});
      if (n >= p1lo && n <= p1hi)
        check({tag, " frozen1"}, {29'd0, bus.B, bus.C, bus.D}, {29'd0, p1code});
      if (n >= p2lo && n <= p2hi)
        check({tag, " frozen2"}, {29'd0, bus.B, bus.C, bus.D}, {29'd0, p2code});
      if (bus.done) begin
        seen = 1'b1;
        check({tag, " done_cycle"}, n, exp_done);
        check({tag, " busy_at_done"}, {31'd0, bus.busy}, 0);
        check({tag, " table"}, {24'd0, bus.table_out}, {24'd0, exp_tab});
        check({tag, " ones"}, {28'd0, bus.ones_cnt}, {28'd0, exp_ones});
      end else begin
        @(posedge clk); #1;
        n++;
      end
    end
    if (!seen) check({tag, " done_timeout"}, 0, 1);
    bus.pause = 1'b0;
  endtask

  initial begin
    int n;
    bit any_done;
    bus.start  = 1'b0;
    bus.gray   = 1'b0;
    bus.pause  = 1'b0;
    bus3.start = 1'b0;
    bus3.gray  = 1'b0;
    bus3.pause = 1'b0;

    #12;
    check("rst_code", {29'd0, bus.B, bus.C, bus.D}, 0);
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_done", {31'd0, bus.done}, 0);
    check("rst_table", {24'd0, bus.table_out}, 0);
    check("rst_ones", {28'd0, bus.ones_cnt}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Binary and Gray sweeps; Gray with gray toggling every cycle.
    sweep("bin", 1'b0, 1'b0, 1'b0, 0, -1, 3'd0, 0, -1, 3'd0, 1'b1, 8'hA2, 4'd3, 17);
    sweep("gray", 1'b1, 1'b1, 1'b0, 0, -1, 3'd0, 0, -1, 3'd0, 1'b1, 8'hA2, 4'd3, 17);

    // Pause: 5 cycles in WAIT of idx 3 (cycles 7..11), 2 in SAMPLE of idx 6.
    sweep("pause", 1'b0, 1'b0, 1'b0, 7, 11, 3'd3, 19, 20, 3'd6, 1'b0, 8'hA2, 4'd3, 24);

    // Constant Y.
    y_sel = 1;
    sweep("y1", 1'b0, 1'b0, 1'b0, 0, -1, 3'd0, 0, -1, 3'd0, 1'b0, 8'hFF, 4'd8, 17);
    y_sel = 2;
    sweep("y0", 1'b1, 1'b0, 1'b0, 0, -1, 3'd0, 0, -1, 3'd0, 1'b0, 8'h00, 4'd0, 17);
    y_sel = 0;

    // SETTLE = 3 instance, Y tied high.
    @(posedge clk); #1;
    bus3.start = 1'b1;
    @(posedge clk); #1;
    bus3.start = 1'b0;
    n = 1;
    @(negedge clk);
    while (!bus3.done && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("s3_done_cycle", n, 33);
    check("s3_table", {24'd0, bus3.table_out}, 32'hFF);
    check("s3_ones", {28'd0, bus3.ones_cnt}, 8);

    // Reset mid-sweep while idx = 4 (cycle 9).
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.gray  = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("mid_code_before", {29'd0, bus.B, bus.C, bus.D}, 4);
    check("mid_table_before", {24'd0, bus.table_out}, 32'h02);
    rst_n = 1'b0;
    #1;
    check("mid_rst_code", {29'd0, bus.B, bus.C, bus.D}, 0);
    check("mid_rst_busy", {31'd0, bus.busy}, 0);
    check("mid_rst_table", {24'd0, bus.table_out}, 0);
    check("mid_rst_ones", {28'd0, bus.ones_cnt}, 0);
    any_done = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) any_done = 1'b1;
    end
    check("mid_no_done", {31'd0, any_done}, 0);
    sweep("after_rst", 1'b0, 1'b0, 1'b0, 0, -1, 3'd0, 0, -1, 3'd0, 1'b1, 8'hA2, 4'd3, 17);

    // Start held high: IDLE cycle after DONE, then a fresh sweep.
    sweep("hold", 1'b0, 1'b0, 1'b1, 0, -1, 3'd0, 0, -1, 3'd0, 1'b1, 8'hA2, 4'd3, 17);
    @(posedge clk); #1;          // cycle 18: IDLE, start accepted at its end
    @(negedge clk);
    check("hold_idle_busy", {31'd0, bus.busy}, 0);
    check("hold_idle_table", {24'd0, bus.table_out}, 32'hA2);
    @(posedge clk); #1;          // cycle 19: first WAIT of second sweep
    @(negedge clk);
    check("hold_busy2", {31'd0, bus.busy}, 1);
    check("hold_table_clr", {24'd0, bus.table_out}, 0);
    check("hold_ones_clr", {28'd0, bus.ones_cnt}, 0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 20;
    @(negedge clk);
    while (!bus.done && n < 80) begin
      @(negedge clk);
      n++;
    end
    check("hold_done2_cycle", n, 35);
    check("hold_table2", {24'd0, bus.table_out}, 32'hA2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
